// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single strobed memory with an MFC handshake.
// Optional feature macro MEM_TIMEOUT_EN: abort a STROBE after TIMEOUT cycles without MFC, pulsing ERR.

module mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        I_REQ,
    input  logic [15:0] I_ADDR,
    output logic        I_ACK,
    output logic [15:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [15:0] D_ADDR,
    input  logic [15:0] D_WDATA,
    output logic        D_ACK,
    output logic [15:0] D_RDATA,
    output logic [15:0] MAR_to_MEM,
    output logic [15:0] MDR_to_MEM,
    output logic        EN,
    output logic        RW,
    input  logic [15:0] MEM_to_MDR,
    input  logic        MFC,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    state_t      state_r, state_s;
    logic [15:0] mar_r, mar_s;
    logic [15:0] mdr_r, mdr_s;
    logic [15:0] i_rdata_r, i_rdata_s;
    logic [15:0] d_rdata_r, d_rdata_s;
    logic        rw_r, rw_s;
    logic        en_r, en_s;
    logic        i_ack_r, i_ack_s;
    logic        d_ack_r, d_ack_s;
    logic        busy_r, busy_s;
    logic        gnt_data_r, gnt_data_s;   // port owning the current access: 1 = data
    logic        last_data_r, last_data_s; // port granted most recently: 1 = data
    logic        fetch_wins_s;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             err_r, err_s;
    logic             expired_s;

    assign expired_s = (cnt_r == CNT_W'(TIMEOUT - 1));
`endif

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_s     = state_r;
        mar_s       = mar_r;
        mdr_s       = mdr_r;
        rw_s        = rw_r;
        en_s        = 1'b0;
        i_ack_s     = 1'b0;
        d_ack_s     = 1'b0;
        i_rdata_s   = i_rdata_r;
        d_rdata_s   = d_rdata_r;
        gnt_data_s  = gnt_data_r;
        last_data_s = last_data_r;
`ifdef MEM_TIMEOUT_EN
        cnt_s       = cnt_r;
        err_s       = 1'b0;
`endif
        // On a tie the port that did not win last time gets the memory.
        fetch_wins_s = I_REQ && (!D_REQ || last_data_r);

        case (state_r)
            ST_IDLE: begin
                if (I_REQ || D_REQ) begin
                    state_s     = ST_SETUP;
                    gnt_data_s  = !fetch_wins_s;
                    last_data_s = !fetch_wins_s;
                    if (fetch_wins_s) begin
                        mar_s = I_ADDR;
                        mdr_s = 16'h0000;
                        rw_s  = 1'b1;
                    end else begin
                        mar_s = D_ADDR;
                        mdr_s = D_WDATA;
                        rw_s  = !D_WE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_STROBE;
                en_s    = 1'b1;
`ifdef MEM_TIMEOUT_EN
                cnt_s   = '0;
`endif
            end
            ST_STROBE: begin
                if (MFC) begin
                    state_s = ST_RELEASE;
                    i_ack_s = !gnt_data_r;
                    d_ack_s = gnt_data_r;
                    if (rw_r && gnt_data_r) begin
                        d_rdata_s = MEM_to_MDR;
                    end else if (rw_r) begin
                        i_rdata_s = MEM_to_MDR;
                    end else begin
                        d_rdata_s = d_rdata_r;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (expired_s) begin
                    state_s = ST_RELEASE;
                    i_ack_s = !gnt_data_r;
                    d_ack_s = gnt_data_r;
                    err_s   = 1'b1;
                end else begin
                    en_s  = 1'b1;
                    cnt_s = cnt_r + CNT_W'(1);
                end
`else
                else begin
                    en_s = 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                if (!MFC) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers; reset parks the pointer on data so the first tie goes to fetch.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_r     <= ST_IDLE;
            mar_r       <= 16'h0000;
            mdr_r       <= 16'h0000;
            rw_r        <= 1'b1;
            en_r        <= 1'b0;
            i_ack_r     <= 1'b0;
            d_ack_r     <= 1'b0;
            i_rdata_r   <= 16'h0000;
            d_rdata_r   <= 16'h0000;
            busy_r      <= 1'b0;
            gnt_data_r  <= 1'b0;
            last_data_r <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_r       <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            mar_r       <= mar_s;
            mdr_r       <= mdr_s;
            rw_r        <= rw_s;
            en_r        <= en_s;
            i_ack_r     <= i_ack_s;
            d_ack_r     <= d_ack_s;
            i_rdata_r   <= i_rdata_s;
            d_rdata_r   <= d_rdata_s;
            busy_r      <= busy_s;
            gnt_data_r  <= gnt_data_s;
            last_data_r <= last_data_s;
`ifdef MEM_TIMEOUT_EN
            cnt_r       <= cnt_s;
            err_r       <= err_s;
`endif
        end
    end

    assign MAR_to_MEM = mar_r;
    assign MDR_to_MEM = mdr_r;
    assign RW         = rw_r;
    assign EN         = en_r;
    assign I_ACK      = i_ack_r;
    assign D_ACK      = d_ack_r;
    assign I_RDATA    = i_rdata_r;
    assign D_RDATA    = d_rdata_r;
    assign BUSY       = busy_r;
`ifdef MEM_TIMEOUT_EN
    assign ERR        = err_r;
`else
    assign ERR        = 1'b0;
`endif

endmodule
